rv_test_harness: RTL and testbench

Parametrised successor of the single-cycle simulation top, used as the core's memory and result-monitor shell. The block holds the instruction and data memories and a host programming port that loads both. A run-control FSM clears, programs, runs and halts the core, and it latches pass, fail and timeout status. The core attaches through the core-side ports; the harness never instantiates the core itself.

---
 rtl/rv_test_harness.sv | 226 ++++++++++++++++++++++
 tb/tb_rv_test_harness.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_test_harness.sv
// Memory and result-monitor shell for the core: imem/dmem, host programming port, run-control FSM.
// Optional out-of-bounds fetch checking is enabled by defining OOB_CHECK_EN.
module rv_test_harness #(
    parameter int          INST_MEM_ADDR_SIZE = 10,
    parameter int          DATA_MEM_ADDR_SIZE = 10,
    parameter int          PROG_ADDR_W        = 16,
    parameter logic [31:0] RESULT_ADDR        = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES     = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_prog_valid,
    output logic                   o_prog_ready,
    input  logic                   i_prog_target,
    input  logic [PROG_ADDR_W-1:0] i_prog_addr,
    input  logic [31:0]            i_prog_data,
    input  logic                   i_prog_done,
    output logic                   o_core_reset,
    input  logic [31:0]            i_pc,
    output logic [31:0]            o_instr,
    input  logic [31:0]            i_mem_addr,
    input  logic [31:0]            i_mem_wdata,
    input  logic [2:0]             i_funct3,
    input  logic                   i_mem_we,
    output logic [31:0]            o_read_data,
    output logic                   o_result_valid,
    output logic                   o_result_passed,
    output logic                   o_result_timeout,
    output logic                   o_result_error,
    output logic [31:0]            o_cycle_count
);

    localparam int IIDX_W = INST_MEM_ADDR_SIZE;
    localparam int DIDX_W = DATA_MEM_ADDR_SIZE - 2;
    localparam int IDEPTH = 1 << IIDX_W;
    localparam int DDEPTH = 1 << DIDX_W;
    localparam int CNT_W  = (IIDX_W > DIDX_W) ? IIDX_W : DIDX_W;

    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_PROG,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_imem [IDEPTH];
    logic [31:0] r_dmem [DDEPTH];

    logic [CNT_W-1:0] r_clr_cnt;
    logic [31:0]      r_cycle;
    logic             r_passed;
    logic             r_timeout;
    logic             r_error;

    logic [IIDX_W-1:0] w_iidx;
    logic [DIDX_W-1:0] w_didx;
    logic [31:0]       w_rdata;
    logic [3:0]        w_base;
    logic [7:0]        w_strb8;
    logic [3:0]        w_strb;
    logic [31:0]       w_wsh;
    logic [31:0]       w_merged;
    logic              w_store;
    logic              w_result;
    logic              w_tmo;
    logic              w_oob;
    logic              w_clr_last;
    logic              w_end_pass;
    logic              w_end_tmo;
    logic              w_end_err;
    logic              w_unused;

    assign w_iidx  = i_pc[IIDX_W+1:2];
    assign w_didx  = i_mem_addr[DATA_MEM_ADDR_SIZE-1:2];
    assign w_rdata = r_dmem[w_didx];

    assign o_instr     = r_imem[w_iidx];
    assign o_read_data = w_rdata;

    always_comb begin
        w_base = 4'b0000;
        unique case (i_funct3[1:0])
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            2'b10:   w_base = 4'b1111;
            default: w_base = 4'b0000;
        endcase
    end

    // Lanes pushed past byte 3 fall off the top rather than wrapping.
    assign w_strb8 = {4'b0000, w_base} << i_mem_addr[1:0];
    assign w_strb  = w_strb8[3:0];
    assign w_wsh   = i_mem_wdata << {i_mem_addr[1:0], 3'b000};

    always_comb begin
        w_merged = w_rdata;
        for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) begin
                w_merged[8*b +: 8] = w_wsh[8*b +: 8];
            end
        end
    end

    assign w_store  = (r_state == S_RUN) && i_mem_we
                      && (i_mem_addr != RESULT_ADDR);
    assign w_result = (r_state == S_RUN) && i_mem_we
                      && (i_mem_addr == RESULT_ADDR)
                      && (i_funct3 == 3'b000);
    assign w_tmo    = TO_EN && (r_cycle == TO_LAST);

`ifdef OOB_CHECK_EN
    assign w_oob = (i_pc[1:0] != 2'b00)
                   || ((i_pc >> (IIDX_W + 2)) != 32'd0);
`else
    assign w_oob = 1'b0;
`endif

    assign w_clr_last = (r_clr_cnt == {CNT_W{1'b1}});

    always_comb begin
        w_next     = r_state;
        w_end_pass = 1'b0;
        w_end_tmo  = 1'b0;
        w_end_err  = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_next = S_PROG;
                end
            end
            S_PROG: begin
                if (i_prog_done) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_oob) begin
                    w_next    = S_DONE;
                    w_end_err = 1'b1;
                end else if (w_result) begin
                    w_next     = S_DONE;
                    w_end_pass = (i_mem_wdata == 32'd1);
                end else if (w_tmo) begin
                    w_next    = S_DONE;
                    w_end_tmo = 1'b1;
                end
            end
            default: w_next = S_DONE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_cycle   <= '0;
            r_passed  <= 1'b0;
            r_timeout <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if ((r_state == S_RUN) && (r_cycle != 32'hFFFF_FFFF)) begin
                r_cycle <= r_cycle + 32'd1;
            end
            if ((r_state == S_RUN) && (w_next == S_DONE)) begin
                r_passed  <= w_end_pass;
                r_timeout <= w_end_tmo;
                r_error   <= w_end_err;
            end
        end
    end

    // Memories carry no reset; CLEAR wipes them after every reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == S_CLEAR) begin
                if (32'(r_clr_cnt) < 32'(IDEPTH)) begin
                    r_imem[r_clr_cnt[IIDX_W-1:0]] <= 32'd0;
                end
            end else if ((r_state == S_PROG) && i_prog_valid
                         && !i_prog_target) begin
                r_imem[i_prog_addr[IIDX_W-1:0]] <= i_prog_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == S_CLEAR) begin
                if (32'(r_clr_cnt) < 32'(DDEPTH)) begin
                    r_dmem[r_clr_cnt[DIDX_W-1:0]] <= 32'd0;
                end
            end else if ((r_state == S_PROG) && i_prog_valid
                         && i_prog_target) begin
                r_dmem[i_prog_addr[DIDX_W-1:0]] <= i_prog_data;
            end else if (w_store) begin
                r_dmem[w_didx] <= w_merged;
            end
        end
    end

    assign o_prog_ready     = (r_state == S_PROG);
    assign o_core_reset     = (r_state != S_RUN);
    assign o_result_valid   = (r_state == S_DONE);
    assign o_result_passed  = r_passed;
    assign o_result_timeout = r_timeout;
    assign o_cycle_count    = r_cycle;

`ifdef OOB_CHECK_EN
    assign o_result_error = r_error;
`else
    assign o_result_error = 1'b0;
`endif

    assign w_unused = ^{i_pc, i_prog_addr, r_error};

endmodule

// File: tb/tb_rv_test_harness.sv
// Randomized bench for rv_test_harness against a behavioural model.
// Expects OOB_CHECK_EN results only when the same macro is defined here.
module tb_rv_test_harness;

    localparam int ID = 1024;
    localparam int DD = 256;
    localparam int TO = 20;
    localparam int P_CLEAR = 0;
    localparam int P_PROG  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_valid;
    logic        prog_ready;
    logic        prog_target;
    logic [15:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_done;
    logic        core_reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  funct3;
    logic        mem_we;
    logic [31:0] read_data;
    logic        result_valid;
    logic        result_passed;
    logic        result_timeout;
    logic        result_error;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    rv_test_harness #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_prog_valid(prog_valid),
        .o_prog_ready(prog_ready),
        .i_prog_target(prog_target),
        .i_prog_addr(prog_addr),
        .i_prog_data(prog_data),
        .i_prog_done(prog_done),
        .o_core_reset(core_reset),
        .i_pc(pc),
        .o_instr(instr),
        .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata),
        .i_funct3(funct3),
        .i_mem_we(mem_we),
        .o_read_data(read_data),
        .o_result_valid(result_valid),
        .o_result_passed(result_passed),
        .o_result_timeout(result_timeout),
        .o_result_error(result_error),
        .o_cycle_count(cycle_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Behavioural model: phases, a clear countdown and byte-wise stores.
    logic [31:0] m_imem [ID];
    logic [31:0] m_dmem [DD];
    int          m_phase;
    int          m_clr;
    logic [31:0] m_cyc;
    bit          m_pass, m_to, m_err;

    always @(posedge clk) begin
        bit          oob, res;
        int          nb, off, wi;
        logic [31:0] w;
        if (reset) begin
            m_phase = P_CLEAR;
            m_clr   = 0;
            m_cyc   = 0;
            m_pass  = 0;
            m_to    = 0;
            m_err   = 0;
        end else begin
            case (m_phase)
                P_CLEAR: begin
                    m_imem[m_clr] = 0;
                    if (m_clr < DD) m_dmem[m_clr] = 0;
                    m_clr++;
                    if (m_clr == ID) m_phase = P_PROG;
                end
                P_PROG: begin
                    if (prog_valid) begin
                        if (prog_target) m_dmem[prog_addr % DD] = prog_data;
                        else m_imem[prog_addr % ID] = prog_data;
                    end
                    if (prog_done) m_phase = P_RUN;
                end
                P_RUN: begin
                    oob = 0;
`ifdef OOB_CHECK_EN
                    oob = (pc % 4 != 0) || (pc >= 32'h1000);
`endif
                    res = mem_we && mem_addr == 32'hFFFF_FFFF && funct3 == 0;
                    if (mem_we && mem_addr != 32'hFFFF_FFFF) begin
                        case (funct3[1:0])
                            2'd0: nb = 1;
                            2'd1: nb = 2;
                            2'd2: nb = 4;
                            default: nb = 0;
                        endcase
                        off = int'(mem_addr % 4);
                        wi  = int'((mem_addr % 1024) / 4);
                        w   = m_dmem[wi];
                        for (int b = 0; b < nb; b++)
                            if (off + b < 4) w[8*(off+b) +: 8] = mem_wdata[8*b +: 8];
                        m_dmem[wi] = w;
                    end
                    if (oob) begin
                        m_err = 1; m_phase = P_DONE;
                    end else if (res) begin
                        m_pass = (mem_wdata == 1); m_phase = P_DONE;
                    end else if (m_cyc == TO - 1) begin
                        m_to = 1; m_phase = P_DONE;
                    end
                    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_reset", core_reset, m_phase != P_RUN);
            chk("prog_ready", prog_ready, m_phase == P_PROG);
            chk("result_valid", result_valid, m_phase == P_DONE);
            chk("result_passed", result_passed, m_pass);
            chk("result_timeout", result_timeout, m_to);
            chk("result_error", result_error, m_err);
            chk("cycle_count", cycle_count, m_cyc);
            if (m_phase != P_CLEAR) begin
                chk("instr", instr, m_imem[pc[11:2]]);
                chk("read_data", read_data, m_dmem[mem_addr[9:2]]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        prog_valid = 0; prog_done = 0; mem_we = 0;
        pc = 0; funct3 = 0; mem_addr = 0; mem_wdata = 0;
    endtask

    task automatic reset_clear();
        int n;
        idle();
        reset = 1; step(); step();
        reset = 0;
        n = 0;
        while (!prog_ready && n < 2000) begin
            step(); n++;
        end
        chk("clear_len", n, 1024);
    endtask

    task automatic prog(input bit tgt, input logic [15:0] a,
                        input logic [31:0] d, input bit done);
        prog_valid = 1; prog_target = tgt; prog_addr = a;
        prog_data = d; prog_done = done;
        step();
        prog_valid = 0; prog_done = 0;
    endtask

    task automatic run_idle(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_run();
        for (int i = 0; i < 30 && m_phase == P_RUN; i++) begin
            pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 15) == 0) pc = $urandom;
            mem_we    = 1'($urandom);
            funct3    = 3'($urandom);
            mem_addr  = 32'($urandom_range(0, 1023));
            mem_wdata = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                mem_addr  = 32'hFFFF_FFFF;
                mem_wdata = 32'($urandom_range(0, 2));
            end
            prog_valid  = 1'($urandom);
            prog_target = 1'($urandom);
            prog_addr   = 16'($urandom);
            prog_data   = $urandom;
            step();
        end
        run_idle(2);
    endtask

    task automatic result_at(input int cyc, input logic [31:0] val);
        prog(0, 16'd0, 32'h13, 1);
        run_idle(cyc);
        mem_we = 1; funct3 = 0;
        mem_addr = 32'hFFFF_FFFF; mem_wdata = val;
        step();
        idle();
    endtask

    logic [31:0] iw [4];

    initial begin
        idle();
        prog_target = 0; prog_addr = 0; prog_data = 0;
        reset = 1;
        step();
        chk_en = 1;

        reset_clear();
        prog(0, 16'd5, 32'h1111_1111, 0);
        prog(1, 16'd5, 32'h2222_2222, 0);
        reset_clear();
        pc = 32'd20; mem_addr = 32'd20; #1;
        chk("imem5_cleared", instr, 32'd0);
        chk("dmem5_cleared", read_data, 32'd0);

        for (int i = 0; i < 4; i++) begin
            iw[i] = $urandom;
            prog(0, 16'(i), iw[i], 0);
        end
        prog(1, 16'd2, 32'hDEAD_BEEF, 1);
        chk("core_reset_fall", core_reset, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4); #1;
            chk("imem_prog", instr, iw[i]);
        end
        mem_addr = 32'd8; #1;
        chk("dmem2_prog", read_data, 32'hDEAD_BEEF);

        mem_we = 1; funct3 = 3'b000; mem_addr = 32'h9; mem_wdata = 32'hAB;
        step();
        funct3 = 3'b001; mem_addr = 32'hB; mem_wdata = 32'h1234;
        step();
        funct3 = 3'b010; mem_addr = 32'h10; mem_wdata = 32'h55;
        step();
        idle();
        mem_addr = 32'h8; #1;
        chk("sb_sh_word2", read_data, 32'h34AD_ABEF);
        mem_addr = 32'hC; #1;
        chk("sh_no_wrap", read_data, 32'd0);
        mem_addr = 32'h10; #1;
        chk("sw_word4", read_data, 32'h0000_0055);
        rand_run();

        reset_clear();
        result_at(7, 32'd1);
        chk("pass_valid", result_valid, 1'b1);
        chk("pass_passed", result_passed, 1'b1);
        chk("pass_cycles", cycle_count, 32'd8);
        chk("pass_core_reset", core_reset, 1'b1);
        prog(0, 16'd0, 32'hFFFF_0000, 1);
        run_idle(3);
        chk("done_hold_cycles", cycle_count, 32'd8);

        reset_clear();
        result_at(7, 32'd2);
        chk("fail_valid", result_valid, 1'b1);
        chk("fail_passed", result_passed, 1'b0);

        reset_clear();
        prog(0, 16'd0, 32'h13, 1);
        run_idle(19);
        chk("to_not_yet", result_valid, 1'b0);
        step();
        chk("to_valid", result_valid, 1'b1);
        chk("to_timeout", result_timeout, 1'b1);
        chk("to_cycles", cycle_count, 32'd20);

        reset_clear();
        result_at(19, 32'd1);
        chk("late_pass_timeout", result_timeout, 1'b0);
        chk("late_pass_passed", result_passed, 1'b1);
        chk("late_pass_cycles", cycle_count, 32'd20);

        for (int s = 0; s < 4; s++) begin
            reset_clear();
            for (int i = 0; i < 8; i++) begin
                prog(1'($urandom), 16'($urandom), $urandom, 0);
            end
            prog(1'($urandom), 16'($urandom), $urandom, 1);
            rand_run();
        end

        reset_clear();
        prog(0, 16'd0, 32'h13, 1);
        run_idle(2);
        pc = 32'h1002;
        step();
        idle();
`ifdef OOB_CHECK_EN
        chk("oob_error", result_error, 1'b1);
        chk("oob_valid", result_valid, 1'b1);
`else
        chk("oob_off_valid", result_valid, 1'b0);
        run_idle(20);
        chk("oob_off_to", result_timeout, 1'b1);
`endif
        reset = 1;
        step();
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_error", result_error, 1'b0);
        chk("rst_timeout", result_timeout, 1'b0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_ready", prog_ready, 1'b0);
        chk("rst_core_reset", core_reset, 1'b1);
        reset = 0;
        step();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
